textlcd_buf_ctrl: RTL and testbench

Parametrised HD44780-class text LCD controller for the FPGA board display, 8-bit bus, write-only.
Holds a ROWS x COLS character frame buffer that game logic writes byte-by-byte. Redraws the panel whenever the buffer changes, instead of replaying fixed strings.
Generates a proper LCD_E strobe with setup/hold margins in place of driving E from the clock, and supports an on-demand clear.

---
 rtl/textlcd_buf_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_textlcd_buf_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/textlcd_buf_ctrl.sv
// Text LCD controller (HD44780-class, 8-bit bus, write-only) with a
// ROWS x COLS character frame buffer. The panel is initialised once after
// reset, then redrawn in full whenever the buffer changes. Every bus
// transaction is a fixed slot with an E strobe that has at least one cycle
// of setup and one cycle of hold around it.
module textlcd_buf_ctrl #(
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int SLOT_CYC  = 8,
    parameter int INIT_WAIT = 70,
    parameter int CMD_WAIT  = 30,
    parameter int CLR_WAIT  = 200,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              resetn,      // active-high despite the name
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clear_req,
    output logic              busy,
    output logic              LCD_E,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic [7:0]        LCD_DATA
);

    localparam int NBYTES = ROWS * COLS;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SLOT_W = $clog2(SLOT_CYC);
    localparam int WAIT_W = 16;

    typedef enum logic [2:0] {
        INIT_DLY  = 3'd0,
        FUNC_SET  = 3'd1,
        DISP_ON   = 3'd2,
        ENTRY     = 3'd3,
        CLEAR     = 3'd4,
        IDLE      = 3'd5,
        LINE_ADDR = 3'd6,
        LINE_CHAR = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic                phase_q, phase_d;      // 0: bus slot, 1: post-wait
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                dirty_q, dirty_d;
    logic                clr_pend_q, clr_pend_d;
    logic [7:0]          buf_q [NBYTES];
    logic [7:0]          buf_d [NBYTES];
    logic                busy_q, busy_d;
    logic                lcd_e_q, lcd_e_d;
    logic                lcd_rs_q, lcd_rs_d;
    logic                lcd_rw_q, lcd_rw_d;
    logic [7:0]          lcd_data_q, lcd_data_d;

    logic                advance_s;
    logic                slot_start_s;
    logic                wr_ok_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [IDX_W-1:0]    rd_idx_s;

    // Extra idle cycles that follow the slot of a given command state.
    function automatic logic [WAIT_W-1:0] post_wait(input state_t st);
        case (st)
            FUNC_SET, DISP_ON, ENTRY: post_wait = WAIT_W'(CMD_WAIT);
            CLEAR:                    post_wait = WAIT_W'(CLR_WAIT);
            default:                  post_wait = {WAIT_W{1'b0}};
        endcase
    endfunction

    // States that drive one bus transaction slot.
    function automatic logic is_slot(input state_t st);
        case (st)
            FUNC_SET, DISP_ON, ENTRY, CLEAR, LINE_ADDR, LINE_CHAR: is_slot = 1'b1;
            default:                                              is_slot = 1'b0;
        endcase
    endfunction

    // Command byte put on the bus by each command state.
    function automatic logic [7:0] cmd_byte(input state_t st, input logic row);
        case (st)
            FUNC_SET:  cmd_byte = 8'h3C;
            DISP_ON:   cmd_byte = 8'h0C;
            ENTRY:     cmd_byte = 8'h06;
            CLEAR:     cmd_byte = 8'h01;
            LINE_ADDR: cmd_byte = row ? 8'hC0 : 8'h80;
            default:   cmd_byte = 8'h00;
        endcase
    endfunction

    // Next-state, buffer update and bus output computation.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        slot_d     = slot_q;
        wait_d     = wait_q;
        row_d      = row_q;
        col_d      = col_q;
        dirty_d    = dirty_q;
        clr_pend_d = clr_pend_q;
        buf_d      = buf_q;
        advance_s  = 1'b0;
        lcd_rw_d   = 1'b0;

        case (state_q)
            INIT_DLY: begin
                if (wait_q == WAIT_W'(INIT_WAIT - 1)) begin
                    state_d = FUNC_SET;
                    phase_d = 1'b0;
                    slot_d  = {SLOT_W{1'b0}};
                    wait_d  = {WAIT_W{1'b0}};
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            IDLE: begin
                if (clr_pend_q) begin
                    state_d    = CLEAR;
                    clr_pend_d = 1'b0;
                    phase_d    = 1'b0;
                    slot_d     = {SLOT_W{1'b0}};
                end else if (dirty_q) begin
                    state_d = LINE_ADDR;
                    row_d   = 1'b0;
                    dirty_d = 1'b0;
                    phase_d = 1'b0;
                    slot_d  = {SLOT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (!phase_q) begin
                    if (slot_q == SLOT_W'(SLOT_CYC - 1)) begin
                        if (post_wait(state_q) != {WAIT_W{1'b0}}) begin
                            phase_d = 1'b1;
                            wait_d  = {WAIT_W{1'b0}};
                        end else begin
                            advance_s = 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end else begin
                    if (wait_q == post_wait(state_q) - WAIT_W'(1)) begin
                        advance_s = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
        endcase

        if (advance_s) begin
            phase_d = 1'b0;
            slot_d  = {SLOT_W{1'b0}};
            wait_d  = {WAIT_W{1'b0}};
            case (state_q)
                FUNC_SET:  state_d = DISP_ON;
                DISP_ON:   state_d = ENTRY;
                ENTRY:     state_d = CLEAR;
                CLEAR:     state_d = IDLE;
                LINE_ADDR: begin
                    state_d = LINE_CHAR;
                    col_d   = {COL_W{1'b0}};
                end
                LINE_CHAR: begin
                    if (col_q == COL_W'(COLS - 1)) begin
                        if ((ROWS > 1) && !row_q) begin
                            row_d   = 1'b1;
                            state_d = LINE_ADDR;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                default:   state_d = IDLE;
            endcase
        end else begin
            state_d = state_d;
        end

        // Buffer writes; clear_req wins over a same-cycle write.
        wr_ok_s  = ({1'b0, wr_addr} < (ADDR_W + 1)'(NBYTES));
        wr_idx_s = IDX_W'(wr_addr);
        if (clear_req) begin
            for (int i = 0; i < NBYTES; i++) begin
                buf_d[i] = 8'h20;
            end
            clr_pend_d = 1'b1;
            dirty_d    = 1'b1;
        end else if (wr_en && wr_ok_s) begin
            buf_d[wr_idx_s] = wr_data;
            dirty_d         = 1'b1;
        end else begin
            dirty_d = dirty_d;
        end

        // RS/DATA latch on entry to slot cycle 0; E covers cycles 1..SLOT_CYC-2.
        rd_idx_s     = IDX_W'((row_d ? COLS : 0) + int'(col_d));
        slot_start_s = is_slot(state_d) && !phase_d && (slot_d == {SLOT_W{1'b0}});
        if (slot_start_s) begin
            lcd_rs_d = (state_d == LINE_CHAR);
            if (state_d == LINE_CHAR) begin
                lcd_data_d = buf_q[rd_idx_s];
            end else begin
                lcd_data_d = cmd_byte(state_d, row_d);
            end
        end else begin
            lcd_rs_d   = lcd_rs_q;
            lcd_data_d = lcd_data_q;
        end
        lcd_e_d = is_slot(state_d) && !phase_d &&
                  (slot_d >= SLOT_W'(1)) && (slot_d <= SLOT_W'(SLOT_CYC - 2));
        busy_d  = (state_d != IDLE);
    end

    // State, buffer and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= INIT_DLY;
            phase_q    <= 1'b0;
            slot_q     <= {SLOT_W{1'b0}};
            wait_q     <= {WAIT_W{1'b0}};
            row_q      <= 1'b0;
            col_q      <= {COL_W{1'b0}};
            dirty_q    <= 1'b1;
            clr_pend_q <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                buf_q[i] <= 8'h20;
            end
            busy_q     <= 1'b1;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_rw_q   <= 1'b0;
            lcd_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            slot_q     <= slot_d;
            wait_q     <= wait_d;
            row_q      <= row_d;
            col_q      <= col_d;
            dirty_q    <= dirty_d;
            clr_pend_q <= clr_pend_d;
            for (int i = 0; i < NBYTES; i++) begin
                buf_q[i] <= buf_d[i];
            end
            busy_q     <= busy_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_rw_q   <= lcd_rw_d;
            lcd_data_q <= lcd_data_d;
        end
    end

    assign busy     = busy_q;
    assign LCD_E    = lcd_e_q;
    assign LCD_RS   = lcd_rs_q;
    assign LCD_RW   = lcd_rw_q;
    assign LCD_DATA = lcd_data_q;

endmodule

// File: tb/tb_textlcd_buf_ctrl.sv
// Directed bench for textlcd_buf_ctrl: records every E pulse ({RS,DATA} at
// the rising edge, pulse widths and low gaps) and compares against
// hand-built expected bus sequences. ADDR_W is widened to 6 so that an
// out-of-range index (40) can be presented.
module tb_textlcd_buf_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       clear_req;
    logic       busy;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    textlcd_buf_ctrl #(.ADDR_W(6)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clear_req(clear_req),
        .busy     (busy),
        .LCD_E    (LCD_E),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_DATA (LCD_DATA)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;

    // Bus monitor state (written only by the monitor process)
    int         cyc       = 0;
    logic       e_prev    = 1'b0;
    int         rise_cyc  = 0;
    int         fall_cyc  = 0;
    bit         have_fall = 1'b0;
    logic [8:0] pulse_q[$];
    int         rise_at_q[$];
    int         width_q[$];
    int         gap_q[$];

    // Expected data
    logic [8:0] exp_q[$];
    logic [7:0] tb_buf [32];

    // Samples the bus at each falling clock edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (LCD_E === 1'b1 && e_prev === 1'b0) begin
            pulse_q.push_back({LCD_RS, LCD_DATA});
            rise_at_q.push_back(cyc);
            if (have_fall) gap_q.push_back(cyc - fall_cyc);
            rise_cyc = cyc;
        end
        if (LCD_E !== 1'b1 && e_prev === 1'b1) begin
            width_q.push_back(cyc - rise_cyc);
            fall_cyc  = cyc;
            have_fall = 1'b1;
        end
        e_prev = LCD_E;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(9'h03C);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_refresh();
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, tb_buf[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, tb_buf[i]});
    endtask

    task automatic check_seq(input string tag, input int base);
        chk({tag, "_len"}, pulse_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < pulse_q.size())
                chk($sformatf("%s_%0d", tag, i), pulse_q[base + i], exp_q[i]);
        end
    endtask

    task automatic wait_pulses(input string tag, input int count, input int limit);
        int n = 0;
        while (pulse_q.size() < count && n < limit) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_pulses"}, (pulse_q.size() >= count), 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_E"},    LCD_E,    1'b0);
        chk({tag, "_RS"},   LCD_RS,   1'b0);
        chk({tag, "_RW"},   LCD_RW,   1'b0);
        chk({tag, "_DATA"}, LCD_DATA, 8'h00);
        chk({tag, "_busy"}, busy,     1'b1);
    endtask

    initial begin
        int base, rel_cyc, wbase, gbase, wmin, wmax, gmin;
        bit busy_seen;

        resetn = 1'b0; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 8'h00; clear_req = 1'b0;
        for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;

        // Reset values
        #2 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst");

        // 1: init sequence followed by a blank redraw
        resetn  = 1'b0;
        rel_cyc = cyc;
        base    = pulse_q.size();
        wait_pulses("init", base + 38, 3000);
        wait_idle("init", 200);
        exp_q.delete();
        push_init();
        push_refresh();
        check_seq("init", base);
        if (rise_at_q.size() > base)
            chk("init_delay", (rise_at_q[base] - rel_cyc >= 70), 1'b1);
        repeat (100) @(posedge clk);
        #1;
        chk("init_quiet_cnt", pulse_q.size() - base, 38);
        chk("init_quiet_E", LCD_E, 1'b0);
        chk("init_quiet_busy", busy, 1'b0);

        // 2: two writes; the second lands mid-refresh and forces one more pass
        base  = pulse_q.size();
        wbase = width_q.size();
        gbase = gap_q.size();
        wr(6'd0, 8'h41);
        tb_buf[0] = 8'h41;
        repeat (3) @(posedge clk);
        #1;
        wr(6'd31, 8'h21);
        tb_buf[31] = 8'h21;
        wait_pulses("wr2", base + 68, 3000);
        wait_idle("wr2", 200);
        exp_q.delete();
        push_refresh();
        push_refresh();
        check_seq("wr2", base);
        wmin = 1000; wmax = 0; gmin = 1000;
        for (int i = wbase; i < width_q.size(); i++) begin
            if (width_q[i] < wmin) wmin = width_q[i];
            if (width_q[i] > wmax) wmax = width_q[i];
        end
        for (int i = gbase + 1; i < gap_q.size(); i++)
            if (gap_q[i] < gmin) gmin = gap_q[i];
        chk("e_width_min", wmin, 6);
        chk("e_width_max", wmax, 6);
        chk("e_gap_ge2", (gmin >= 2), 1'b1);

        // 3: out-of-range write is ignored
        base = pulse_q.size();
        wr(6'd40, 8'h5A);
        busy_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        chk("oor_busy", busy_seen, 1'b0);
        chk("oor_pulses", pulse_q.size() - base, 0);

        // 4: write during the 5th character slot of a refresh
        base = pulse_q.size();
        wr(6'd0, 8'h41);
        wait_pulses("mid_5th", base + 6, 500);
        wr(6'd17, 8'h42);
        tb_buf[17] = 8'h42;
        wait_pulses("mid", base + 68, 3000);
        wait_idle("mid", 200);
        repeat (50) @(posedge clk);
        #1;
        exp_q.delete();
        push_refresh();
        push_refresh();
        check_seq("mid", base);

        // 5: clear_req with a same-cycle write (write dropped)
        base = pulse_q.size();
        clear_req = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'h58;
        @(posedge clk); #1;
        clear_req = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
        wait_pulses("clr", base + 35, 3000);
        wait_idle("clr", 200);
        exp_q.delete();
        exp_q.push_back(9'h001);
        push_refresh();
        check_seq("clr", base);

        // 6: reset asserted during a LINE_CHAR slot
        wr(6'd5, 8'h33);
        base = pulse_q.size();
        wait_pulses("mrst_char", base + 3, 500);
        #2 resetn = 1'b1;
        #1;
        check_reset_outs("mrst");
        repeat (3) @(posedge clk);
        #1;
        resetn  = 1'b0;
        rel_cyc = cyc;
        base    = pulse_q.size();
        for (int i = 0; i < 32; i++) tb_buf[i] = 8'h20;
        wait_pulses("mrst", base + 38, 3000);
        wait_idle("mrst", 200);
        exp_q.delete();
        push_init();
        push_refresh();
        check_seq("mrst", base);
        if (rise_at_q.size() > base)
            chk("mrst_delay", (rise_at_q[base] - rel_cyc >= 70), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
